// File: rtl/sram_controller_if.sv
// ============================================================================
// Module : sram_controller_if
// Requester-side bus of the SRAM controller (request, data, completion).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sram_controller_if;
  logic        W_EN;
  logic        R_EN;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [63:0] read_data;
  logic        ready;

  modport master (
    output W_EN, R_EN, address, data_in,
    input  read_data, ready
  );

  modport slave (
    input  W_EN, R_EN, address, data_in,
    output read_data, ready
  );
endinterface

`default_nettype wire

// File: rtl/sram_controller.sv
// ============================================================================
// Module : sram_controller
// Bridges 32-bit writes and 64-bit line reads onto a 16-bit asynchronous SRAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_controller #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [17:0]        SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] c_LAST_CYC = 4'(ACCESS_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cyc_q,   cyc_d;
  logic [1:0]  beat_q,  beat_d;
  logic [16:0] eff_q,   eff_d;    // halfword-pair index: eff[18:2]
  logic [31:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;

  logic [31:0] w_eff;
  logic        w_unused;
  logic        w_last_cyc;
  logic        w_dq_oe;
  logic [15:0] w_dq_out;
  logic        w_ready;

  assign w_eff      = bus.address - BASE_ADDR;
  assign w_unused   = ^{w_eff[31:19], w_eff[1:0]};
  assign w_last_cyc = (cyc_q == c_LAST_CYC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 4'd0;
      beat_q  <= 2'd0;
      eff_q   <= 17'd0;
      wdata_q <= 32'd0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      beat_q  <= beat_d;
      eff_q   <= eff_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    beat_d    = beat_q;
    eff_d     = eff_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    SRAM_ADDR = 18'd0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_CE_N = 1'b1;
    w_dq_oe   = 1'b0;
    w_dq_out  = 16'd0;
    w_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        w_ready = ~(bus.W_EN | bus.R_EN);
        cyc_d   = 4'd0;
        beat_d  = 2'd0;
        if (bus.W_EN || bus.R_EN) begin
          eff_d   = w_eff[18:2];
          wdata_d = bus.data_in;
          state_d = bus.W_EN ? WRITE : READ;
        end
      end

      READ: begin
        SRAM_ADDR = {eff_q[16:1], 2'b00} + {16'd0, beat_q};
        SRAM_OE_N = 1'b0;
        SRAM_CE_N = 1'b0;
        if (w_last_cyc) begin
          rdata_d[{beat_q, 4'b0000} +: 16] = SRAM_DQ;
          cyc_d  = 4'd0;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = DONE;
          end
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end

      WRITE: begin
        SRAM_ADDR = {eff_q, beat_q[0]};
        SRAM_CE_N = 1'b0;
        // WE_N rises on the final cycle so the SRAM latches while data/addr are still held.
        SRAM_WE_N = w_last_cyc;
        w_dq_oe   = 1'b1;
        w_dq_out  = beat_q[0] ? wdata_q[31:16] : wdata_q[15:0];
        if (w_last_cyc) begin
          cyc_d  = 4'd0;
          beat_d = beat_q + 2'd1;
          if (beat_q[0]) begin
            state_d = DONE;
          end
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end

      DONE: begin
        w_ready = 1'b1;
        cyc_d   = 4'd0;
        beat_d  = 2'd0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign SRAM_UB_N     = SRAM_CE_N;
  assign SRAM_LB_N     = SRAM_CE_N;
  assign SRAM_DQ       = w_dq_oe ? w_dq_out : 16'hzzzz;
  assign bus.read_data = rdata_q;
  assign bus.ready     = w_ready;

endmodule

`default_nettype wire
